// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the register-read stage and the mult/div unit.
// The master drives operands and control; the slave returns status and Hi/Lo.
interface mult_div_unit_if #(parameter int WIDTH = 16);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, inA, inB, mthi, mtlo,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, inA, inB, mthi, mtlo,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply (shift-add) / restoring divide owning the Hi/Lo pair.
// States: IDLE waits for start or mthi/mtlo, RUN iterates WIDTH times, FIX signs and writes Hi/Lo.
module mult_div_unit #(
  parameter int WIDTH = 16
) (
  input logic            clock,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t             r_state;
  logic [1:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_in_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;

  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_dbz;

  // Magnitudes stay WIDTH-bit unsigned, so negating 0x8000 yields 0x8000 correctly.
  assign w_signed = ~bus.op[0];
  assign w_abs_a  = (w_signed && bus.inA[WIDTH-1]) ? -bus.inA : bus.inA;
  assign w_abs_b  = (w_signed && bus.inB[WIDTH-1]) ? -bus.inB : bus.inB;

  // r_acc: upper half is partial product / remainder, lower half is multiplier / dividend-quotient.
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_dbz  = r_op[1] && (r_opnd == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_in_a  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_op    <= bus.op;
            r_cnt   <= '0;
            r_in_a  <= bus.inA;
            r_neg_q <= w_signed & (bus.inA[WIDTH-1] ^ bus.inB[WIDTH-1]);
            r_neg_r <= w_signed & bus.inA[WIDTH-1];
            if (bus.op[1]) begin
              r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
              r_opnd <= w_abs_b;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
              r_opnd <= w_abs_a;
            end
          end else begin
            if (bus.mthi) r_hi <= bus.inA;
            if (bus.mtlo) r_lo <= bus.inA;
          end
        end
        S_RUN: begin
          if (r_op[1]) r_acc <= {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
          else         r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (!r_op[1]) begin
            {r_hi, r_lo} <= w_prod;
          end else if (w_dbz) begin
            r_hi  <= r_in_a;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule
